// File: rtl/ksa_multiword_seq.sv
// ksa_multiword_seq: serialises one wide addition over a single pipelined BITS-wide adder,
// issuing slices LSB-first and rippling each slice carry-out into the next slice carry-in.
module ksa_multiword_seq #(
   parameter int BITS     = 16,
   parameter int WORDS    = 4,
   parameter int PIPE_LAT = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WORDS*BITS-1:0] in_a,
   input  logic [WORDS*BITS-1:0] in_b,
   input  logic                  in_c,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORDS*BITS-1:0] out_sum,
   output logic                  out_cout,
   output logic [BITS-1:0]       adder_a,
   output logic [BITS-1:0]       adder_b,
   output logic                  adder_c,
   input  logic [BITS:0]         adder_s
);
   localparam int W  = WORDS * BITS;
   localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
   localparam int CW = PIPE_LAT > 1 ? $clog2(PIPE_LAT) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(PIPE_LAT - 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t          r_state;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [IW-1:0]   r_idx;
   logic [CW-1:0]   r_cnt;
   assign in_ready = r_state == IDLE && !rst;
   // r_a/r_b hold the not-yet-issued upper slices, shifted down one slice per pass;
   // adder_c doubles as the inter-slice carry register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_cnt     <= '0;
         r_a       <= '0;
         r_b       <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
         adder_a   <= '0;
         adder_b   <= '0;
         adder_c   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               adder_a <= in_a[BITS-1:0];
               adder_b <= in_b[BITS-1:0];
               adder_c <= in_c;
               r_a     <= in_a >> BITS;
               r_b     <= in_b >> BITS;
               r_idx   <= '0;
               r_state <= ISSUE;
            end
            ISSUE: begin
               r_cnt   <= '0;
               r_state <= WAIT;
            end
            WAIT: if (r_cnt != LAST_CNT) r_cnt <= r_cnt + 1'b1;
            else begin
               out_sum[r_idx*BITS +: BITS] <= adder_s[BITS-1:0];
               if (r_idx != LAST_IDX) begin
                  adder_a <= r_a[BITS-1:0];
                  adder_b <= r_b[BITS-1:0];
                  adder_c <= adder_s[BITS];
                  r_a     <= r_a >> BITS;
                  r_b     <= r_b >> BITS;
                  r_idx   <= r_idx + 1'b1;
                  r_state <= ISSUE;
               end else begin
                  out_cout  <= adder_s[BITS];
                  out_valid <= 1'b1;
                  r_state   <= DONE;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ksa_multiword_seq.sv
// tb_ksa_multiword_seq: directed vector table plus backpressure and mid-op reset sequences,
// driving the sequencer against a two-register pipelined adder model.
module tb_ksa_multiword_seq;
   localparam int BITS = 16;
   localparam int W    = 64;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic          in_c = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_sum;
   logic          out_cout;
   logic [BITS-1:0] adder_a, adder_b;
   logic          adder_c;
   logic [BITS:0] adder_s;
   logic [BITS-1:0] m_a, m_b;
   logic          m_c;
   int n_vec = 0;
   int n_err = 0;
   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         c;
      logic [W-1:0] s;
      logic         co;
      logic [3:0]   cs;
   } vec_t;
   vec_t v[6];
   ksa_multiword_seq #(.BITS(BITS), .WORDS(4), .PIPE_LAT(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
      .adder_a(adder_a), .adder_b(adder_b), .adder_c(adder_c), .adder_s(adder_s)
   );
   always #5 clk = ~clk;
   // adder model: input register stage then output register stage
   always_ff @(posedge clk) begin
      m_a     <= adder_a;
      m_b     <= adder_b;
      m_c     <= adder_c;
      adder_s <= m_a + m_b + m_c;
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic eco, input logic [3:0] ecs);
      logic       acc;
      logic [3:0] cs;
      int         n;
      in_a = a;
      in_b = b;
      in_c = c;
      in_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) begin
         acc = in_ready;
         tick();
      end
      in_valid = 1'b0;
      in_a = '1;
      in_b = '1;
      in_c = 1'b1;
      chk("accept", W'(acc), W'(1));
      cs = '0;
      n = 1;
      cs[0] = adder_c;
      while (!out_valid && n < 40) begin
         tick();
         n++;
         if (n == 4 || n == 7 || n == 10) cs[(n-1)/3] = adder_c;
      end
      chk("latency", W'(n), W'(13));
      chk("sum", out_sum, es);
      chk("cout", W'(out_cout), W'(eco));
      chk("carry_seq", W'(cs), W'(ecs));
   endtask
   task automatic release_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("valid_after_hs", W'(out_valid), W'(0));
      chk("ready_after_hs", W'(in_ready), W'(1));
   endtask
   initial begin
      v[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 4'b1110};
      v[1] = '{64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, 64'h0011_0022_0033_0045, 1'b0, 4'b0001};
      v[2] = '{64'h0000_FFFF_0000_FFFF, 64'h1, 1'b0, 64'h0000_FFFF_0001_0000, 1'b0, 4'b0010};
      v[3] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 4'b1110};
      v[4] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 4'b0001};
      v[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'b1111};
      tick();
      tick();
      chk("rst_valid", W'(out_valid), W'(0));
      chk("rst_sum", out_sum, W'(0));
      chk("rst_cout", W'(out_cout), W'(0));
      chk("rst_adder", {adder_a, adder_b, 31'd0, adder_c}, W'(0));
      chk("rst_ready", W'(in_ready), W'(0));
      rst = 1'b0;
      #1;
      chk("ready_idle", W'(in_ready), W'(1));
      for (int i = 0; i < 6; i++) begin
         do_op(v[i].a, v[i].b, v[i].c, v[i].s, v[i].co, v[i].cs);
         release_out();
      end
      // backpressure with a second request already waiting
      do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 4'b0000);
      in_a = 64'h5;
      in_b = 64'h3;
      in_c = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("bp_valid", W'(out_valid), W'(1));
         chk("bp_sum", out_sum, W'(0));
         chk("bp_cout", W'(out_cout), W'(1));
         chk("bp_ready", W'(in_ready), W'(0));
      end
      release_out();
      do_op(64'h5, 64'h3, 1'b0, 64'h8, 1'b0, 4'b0000);
      release_out();
      // reset during WAIT of slice 2
      in_a = v[3].a;
      in_b = v[3].b;
      in_c = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 7; k++) tick();
      chk("pre_rst_adder_a", W'(adder_a), W'(16'h5678));
      rst = 1'b1;
      tick();
      chk("mid_rst_valid", W'(out_valid), W'(0));
      chk("mid_rst_sum", out_sum, W'(0));
      chk("mid_rst_adder_a", W'(adder_a), W'(0));
      chk("mid_rst_ready", W'(in_ready), W'(0));
      rst = 1'b0;
      #1;
      chk("post_rst_ready", W'(in_ready), W'(1));
      do_op(64'h5, 64'h3, 1'b0, 64'h8, 1'b0, 4'b0000);
      release_out();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/ksa_multiword_seq.md
Name: ksa_multiword_seq

Overview:
- Upstream operand sequencer for the pipelined Kogge-Stone adder (BITS-wide, registered inputs and outputs).
- Accepts one WORDS*BITS-bit addition over a valid/ready handshake.
- Feeds the adder one BITS-wide slice per pass, least-significant first, chaining each slice's carry-out into the next slice's carry-in.
- Collects the returned slices into a wide sum held behind an output valid/ready handshake. Wide additions therefore reuse one narrow adder instance.

Parameters:
BITS, 16, slice width; must match the adder's BITS
WORDS, 4, slices per operand (>=1)
PIPE_LAT, 2, clock edges from operands appearing on adder_a/b/c to the matching result on adder_s (2 for input-reg + output-reg adder)

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  wide operands present
in_ready  out  1  block can accept operands
in_a  in  WORDS*BITS  operand A
in_b  in  WORDS*BITS  operand B
in_c  in  1  carry-in to slice 0
out_valid  out  1  result held
out_ready  in  1  consumer accepts result
out_sum  out  WORDS*BITS  wide sum
out_cout  out  1  carry-out of top slice
adder_a  out  BITS  slice of A to adder
adder_b  out  BITS  slice of B to adder
adder_c  out  1  carry-in to adder
adder_s  in  BITS+1  adder result; bit BITS is slice carry-out

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: in_ready=0 while rst is high; out_valid=0; out_sum=0; out_cout=0; adder_a=0; adder_b=0; adder_c=0. State returns to IDLE, slice index=0, wait counter=0.
- adder_a, adder_b and adder_c are registered outputs and stay stable for the full pass of a slice.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_a, in_b and in_c. Load adder_a/b with slice 0 and adder_c with in_c. Go to ISSUE.
- ISSUE:
  - First cycle a slice is on the adder bus.
  - Clear the wait counter and go to WAIT.
- WAIT:
  - Count cycles. At the end of the cycle that is PIPE_LAT cycles after the ISSUE cycle, sample adder_s:
    - adder_s[BITS-1:0] goes into out_sum slice i.
    - adder_s[BITS] goes into the carry register.
  - If i<WORDS-1: load slice i+1 on adder_a/b, drive adder_c with the sampled carry, increment i, go to ISSUE.
  - Otherwise: out_cout=adder_s[BITS], out_valid=1, go to DONE.
- Cost: each slice occupies PIPE_LAT+1 cycles (the adder is never overlapped, because the carry is serially dependent).
- Latency: if the accept happens at the end of cycle A, out_valid rises in cycle A+WORDS*(PIPE_LAT+1)+1. With defaults this is 13 cycles after the accept cycle.
- DONE:
  - out_valid=1. out_sum and out_cout are held stable while out_ready=0.
  - On out_ready: out_valid=0, go to IDLE, so in_ready=1 in the next cycle.
  - No new operand is accepted in the same cycle as the result handshake.
- in_ready is 0 in ISSUE, WAIT and DONE. in_valid is ignored there, and in_a/b/c may change freely after acceptance.
- out_sum slices not yet written keep their previous values until overwritten. Only out_valid qualifies them.
- Arithmetic: {out_cout,out_sum} = in_a + in_b + in_c, modulo 2^(WORDS*BITS+1). There is no overflow flag.
- rst asserted mid-operation (any state): the next edge forces the reset values, and the in-flight computation is discarded. Any stale adder_s returned afterwards is ignored because the FSM is in IDLE. The first operation after rst falls produces a correct result.
- WORDS=1: a single ISSUE/WAIT pass, then DONE.

Test Plan:
- (Defaults; adder instance connected.) in_a=0xFFFF_FFFF_FFFF_FFFF, in_b=0x1, in_c=0 -> out_sum=0, out_cout=1, out_valid exactly 13 cycles after the accept cycle. adder_c observed as 0,1,1,1 for slices 0..3.
- in_a=0x0001_0002_0003_0004, in_b=0x0010_0020_0030_0040, in_c=1 -> out_sum=0x0011_0022_0033_0045, out_cout=0. adder_c = 1,0,0,0.
- in_a=0x0000_FFFF_0000_FFFF, in_b=0x1, in_c=0 -> out_sum=0x0000_FFFF_0001_0000, out_cout=0. The carry propagates into slice 1 only.
- Backpressure: the result of 0x8000_0000_0000_0000+0x8000_0000_0000_0000 (out_sum=0, out_cout=1) with out_ready held low for 5 cycles -> out_valid, out_sum and out_cout stable throughout and in_ready=0. In the cycle after out_ready=1, out_valid=0 and in_ready=1. A second in_valid held throughout is accepted only then.
- Reset mid-op: pulse rst for 1 cycle during WAIT of slice 2 -> the next cycle shows out_valid=0, out_sum=0, adder_a=0 and in_ready=1 once rst is low. A following 0x5+0x3, in_c=0 gives out_sum=0x8 and out_cout=0 with 13-cycle latency.
